// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - shared SRAM port arbiter between the 6502 register window and a background requester
//
// Ports:
//   C7M        7M clock, all state changes on its rising edge
//   RES        synchronous reset, active high
//   S          main phase state (0 = unsynced, 1..7 = bus-cycle phase)
//   cpu_*      6502 RAM-register access (select, write, address, write data, registered read data)
//   bg_*       background requester (level request, write, address, write data, ack pulse, read data)
//   RA/RDo     SRAM address and write data
//   RDOE       drive the SRAM data bus
//   RD_in      SRAM read data
//   RAMCS      SRAM chip select, active high
//   nRWE       SRAM write enable, active low

module sram_arbiter #(
    parameter int AW       = 20,
    parameter int FREE_GAP = 4
) (
    input  logic          C7M,
    input  logic          RES,
    input  logic [2:0]    S,
    input  logic          cpu_sel,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [7:0]    cpu_wdata,
    output logic [7:0]    cpu_rdata,
    input  logic          bg_req,
    input  logic          bg_we,
    input  logic [AW-1:0] bg_addr,
    input  logic [7:0]    bg_wdata,
    output logic          bg_ack,
    output logic [7:0]    bg_rdata,
    output logic [AW-1:0] RA,
    output logic [7:0]    RDo,
    output logic          RDOE,
    input  logic [7:0]    RD_in,
    output logic          RAMCS,
    output logic          nRWE
);

    localparam logic [3:0] LP_GAP = 4'(FREE_GAP);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BG_ADDR = 2'd1,
        ST_BG_STB  = 2'd2
    } state_t;

    state_t          r_state;
    logic [3:0]      r_gap;
    logic            r_bg_ack;
    logic [7:0]      r_bg_rdata;
    logic [7:0]      r_cpu_rdata;
    logic [AW-1:0]   r_ra;

    logic            w_cpu_phase;
    logic            w_cpu_win;
    logic            w_bg_start;
    logic            w_bg_active;

    // S4..S7 is the PHI0 half that always belongs to the 6502.
    assign w_cpu_phase = S[2];
    assign w_cpu_win   = (r_state == ST_IDLE) && cpu_sel && w_cpu_phase;
    assign w_bg_active = (r_state == ST_BG_ADDR) || (r_state == ST_BG_STB);

    // Synced: launch only at S1 so ADDR/STB land in S2/S3. Unsynced: throttled by the gap counter.
    assign w_bg_start  = bg_req && ((S == 3'd1) || ((S == 3'd0) && (r_gap == 4'd0)));

    always_ff @(posedge C7M) begin
        if (RES) begin
            r_state     <= ST_IDLE;
            r_gap       <= 4'd0;
            r_bg_ack    <= 1'b0;
            r_bg_rdata  <= 8'h00;
            r_cpu_rdata <= 8'h00;
            r_ra        <= '0;
        end else begin
            r_bg_ack <= 1'b0;
            r_ra     <= RA;

            if ((S == 3'd6) && cpu_sel && !cpu_we) begin
                r_cpu_rdata <= RD_in;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_bg_start) begin
                        r_state <= ST_BG_ADDR;
                    end
                end
                ST_BG_ADDR: begin
                    // A background op still running when the CPU half begins is dropped;
                    // the request stays pending and is retried later.
                    r_state <= w_cpu_phase ? ST_IDLE : ST_BG_STB;
                end
                ST_BG_STB: begin
                    r_state <= ST_IDLE;
                    if (!w_cpu_phase) begin
                        r_bg_ack <= 1'b1;
                        if (!bg_we) begin
                            r_bg_rdata <= RD_in;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase

            // Any synced phase clears the throttle so the first unsynced op can start at once.
            if (S != 3'd0) begin
                r_gap <= 4'd0;
            end else if (r_state == ST_BG_STB) begin
                r_gap <= LP_GAP;
            end else if ((r_state == ST_IDLE) && (r_gap != 4'd0)) begin
                r_gap <= r_gap - 4'd1;
            end
        end
    end

    // Pin mux: background op first, then the CPU window, else park with the last address.
    always_comb begin
        RA    = r_ra;
        RDo   = 8'h00;
        RDOE  = 1'b0;
        RAMCS = 1'b0;
        nRWE  = 1'b1;
        if (w_bg_active) begin
            RA    = bg_addr;
            RDo   = bg_wdata;
            RDOE  = bg_we;
            RAMCS = 1'b1;
            nRWE  = !((r_state == ST_BG_STB) && bg_we);
        end else if (w_cpu_win) begin
            RA    = cpu_addr;
            RDo   = cpu_wdata;
            RDOE  = cpu_we;
            RAMCS = 1'b1;
            // Strobe sits inside S5..S6 so address and data are stable in S4 and S7.
            nRWE  = !(cpu_we && ((S == 3'd5) || (S == 3'd6)));
        end
    end

    assign bg_ack    = r_bg_ack;
    assign bg_rdata  = r_bg_rdata;
    assign cpu_rdata = r_cpu_rdata;

endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - self-checking bench for sram_arbiter

module tb_sram_arbiter;

    localparam int FREE_GAP = 4;

    logic        C7M;
    logic        RES;
    logic [2:0]  S;
    logic        cpu_sel, cpu_we;
    logic [19:0] cpu_addr;
    logic [7:0]  cpu_wdata, cpu_rdata;
    logic        bg_req, bg_we;
    logic [19:0] bg_addr;
    logic [7:0]  bg_wdata;
    logic        bg_ack;
    logic [7:0]  bg_rdata;
    logic [19:0] RA;
    logic [7:0]  RDo;
    logic        RDOE;
    logic [7:0]  RD_in;
    logic        RAMCS, nRWE;

    int n_cmp = 0;
    int n_bad = 0;

    sram_arbiter #(.AW(20), .FREE_GAP(FREE_GAP)) dut (
        .C7M(C7M), .RES(RES), .S(S),
        .cpu_sel(cpu_sel), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
        .bg_req(bg_req), .bg_we(bg_we), .bg_addr(bg_addr), .bg_wdata(bg_wdata),
        .bg_ack(bg_ack), .bg_rdata(bg_rdata),
        .RA(RA), .RDo(RDo), .RDOE(RDOE), .RD_in(RD_in),
        .RAMCS(RAMCS), .nRWE(nRWE)
    );

    initial begin
        C7M = 1'b0;
        forever #5 C7M = ~C7M;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct packed {
        logic [2:0]  s;
        logic        bg_req;
        logic        bg_we;
        logic [19:0] bg_addr;
        logic [7:0]  bg_wdata;
        logic        cpu_sel;
        logic        cpu_we;
        logic [19:0] cpu_addr;
        logic [7:0]  cpu_wdata;
        logic [7:0]  rd_in;
        logic        e_ramcs;
        logic        e_nrwe;
        logic        e_rdoe;
        logic [19:0] e_ra;
        logic [7:0]  e_rdo;
        logic        e_ack;
        logic [7:0]  e_bgr;
        logic [7:0]  e_cpur;
    } vec_t;

    vec_t vecs [22];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge C7M);
        #1;
    endtask

    // Reference model: op_age counts how far a background op has progressed (0 = none).
    int          m_op_age;
    int          m_gap;
    logic        m_ack;
    logic [7:0]  m_bgr, m_cpur;
    logic [19:0] m_ra_last;

    task automatic model_pins(output logic ramcs, output logic nrwe, output logic rdoe,
                              output logic [19:0] ra, output logic [7:0] rdo);
        ramcs = 1'b0; nrwe = 1'b1; rdoe = 1'b0; ra = m_ra_last; rdo = 8'h00;
        if (m_op_age != 0) begin
            ra = bg_addr; ramcs = 1'b1; rdoe = bg_we; rdo = bg_wdata;
            nrwe = (m_op_age == 2 && bg_we) ? 1'b0 : 1'b1;
        end else if (cpu_sel && S >= 3'd4) begin
            ra = cpu_addr; ramcs = 1'b1; rdoe = cpu_we; rdo = cpu_wdata;
            nrwe = (cpu_we && (S == 3'd5 || S == 3'd6)) ? 1'b0 : 1'b1;
        end
    endtask

    task automatic model_edge();
        logic r, n, o;
        logic [19:0] a;
        logic [7:0]  d;
        int old_age;
        model_pins(r, n, o, a, d);
        old_age = m_op_age;
        m_ack = 1'b0;
        if (S == 3'd6 && cpu_sel && !cpu_we) m_cpur = RD_in;
        if (old_age != 0 && S >= 3'd4) m_op_age = 0;
        else if (old_age == 1) m_op_age = 2;
        else if (old_age == 2) begin
            m_op_age = 0;
            m_ack = 1'b1;
            if (!bg_we) m_bgr = RD_in;
        end else if (bg_req && (S == 3'd1 || (S == 3'd0 && m_gap == 0))) m_op_age = 1;
        if (S != 3'd0) m_gap = 0;
        else if (old_age == 2) m_gap = FREE_GAP;
        else if (old_age == 0 && m_gap > 0) m_gap = m_gap - 1;
        m_ra_last = a;
    endtask

    initial begin
        int acks, acks_bc, prev_ramcs, idle_run;
        int starts[$];
        logic [7:0] rd_s6;
        logic pend, saw_ack;
        logic e_ramcs, e_nrwe, e_rdoe;
        logic [19:0] e_ra;
        logic [7:0]  e_rdo;
        logic sync_mode;
        int run;

        vecs[0]  = '{3'd1,1'b1,1'b1,20'h12345,8'hA5, 1'b0,1'b0,20'h00000,8'h00, 8'h00, 1'b0,1'b1,1'b0,20'h00000,8'h00, 1'b0,8'h00,8'h00};
        vecs[1]  = '{3'd2,1'b1,1'b1,20'h12345,8'hA5, 1'b0,1'b0,20'h00000,8'h00, 8'h00, 1'b1,1'b1,1'b1,20'h12345,8'hA5, 1'b0,8'h00,8'h00};
        vecs[2]  = '{3'd3,1'b1,1'b1,20'h12345,8'hA5, 1'b0,1'b0,20'h00000,8'h00, 8'h00, 1'b1,1'b0,1'b1,20'h12345,8'hA5, 1'b0,8'h00,8'h00};
        vecs[3]  = '{3'd4,1'b1,1'b1,20'h12345,8'hA5, 1'b0,1'b0,20'h00000,8'h00, 8'h00, 1'b0,1'b1,1'b0,20'h12345,8'h00, 1'b1,8'h00,8'h00};
        vecs[4]  = '{3'd5,1'b0,1'b1,20'h12345,8'hA5, 1'b0,1'b0,20'h00000,8'h00, 8'h00, 1'b0,1'b1,1'b0,20'h12345,8'h00, 1'b0,8'h00,8'h00};
        vecs[5]  = '{3'd6,1'b0,1'b1,20'h12345,8'hA5, 1'b0,1'b0,20'h00000,8'h00, 8'h00, 1'b0,1'b1,1'b0,20'h12345,8'h00, 1'b0,8'h00,8'h00};
        vecs[6]  = '{3'd7,1'b0,1'b1,20'h12345,8'hA5, 1'b0,1'b0,20'h00000,8'h00, 8'h00, 1'b0,1'b1,1'b0,20'h12345,8'h00, 1'b0,8'h00,8'h00};
        vecs[7]  = '{3'd1,1'b1,1'b0,20'h0ABCD,8'h33, 1'b0,1'b0,20'h00000,8'h00, 8'h00, 1'b0,1'b1,1'b0,20'h12345,8'h00, 1'b0,8'h00,8'h00};
        vecs[8]  = '{3'd2,1'b1,1'b0,20'h0ABCD,8'h33, 1'b0,1'b0,20'h00000,8'h00, 8'h5A, 1'b1,1'b1,1'b0,20'h0ABCD,8'h33, 1'b0,8'h00,8'h00};
        vecs[9]  = '{3'd3,1'b1,1'b0,20'h0ABCD,8'h33, 1'b0,1'b0,20'h00000,8'h00, 8'h5A, 1'b1,1'b1,1'b0,20'h0ABCD,8'h33, 1'b0,8'h00,8'h00};
        vecs[10] = '{3'd4,1'b1,1'b0,20'h0ABCD,8'h33, 1'b0,1'b0,20'h00000,8'h00, 8'h00, 1'b0,1'b1,1'b0,20'h0ABCD,8'h00, 1'b1,8'h5A,8'h00};
        vecs[11] = '{3'd5,1'b0,1'b0,20'h0ABCD,8'h33, 1'b0,1'b0,20'h00000,8'h00, 8'h00, 1'b0,1'b1,1'b0,20'h0ABCD,8'h00, 1'b0,8'h5A,8'h00};
        vecs[12] = '{3'd6,1'b0,1'b0,20'h0ABCD,8'h33, 1'b1,1'b0,20'h00100,8'h77, 8'hC3, 1'b1,1'b1,1'b0,20'h00100,8'h77, 1'b0,8'h5A,8'h00};
        vecs[13] = '{3'd7,1'b0,1'b0,20'h0ABCD,8'h33, 1'b1,1'b0,20'h00100,8'h77, 8'h00, 1'b1,1'b1,1'b0,20'h00100,8'h77, 1'b0,8'h5A,8'hC3};
        vecs[14] = '{3'd1,1'b0,1'b0,20'h0ABCD,8'h33, 1'b0,1'b0,20'h00100,8'h77, 8'h00, 1'b0,1'b1,1'b0,20'h00100,8'h00, 1'b0,8'h5A,8'hC3};
        vecs[15] = '{3'd2,1'b0,1'b0,20'h0ABCD,8'h33, 1'b1,1'b1,20'h54321,8'h9E, 8'h00, 1'b0,1'b1,1'b0,20'h00100,8'h00, 1'b0,8'h5A,8'hC3};
        vecs[16] = '{3'd3,1'b0,1'b0,20'h0ABCD,8'h33, 1'b1,1'b1,20'h54321,8'h9E, 8'h00, 1'b0,1'b1,1'b0,20'h00100,8'h00, 1'b0,8'h5A,8'hC3};
        vecs[17] = '{3'd4,1'b0,1'b0,20'h0ABCD,8'h33, 1'b1,1'b1,20'h54321,8'h9E, 8'h00, 1'b1,1'b1,1'b1,20'h54321,8'h9E, 1'b0,8'h5A,8'hC3};
        vecs[18] = '{3'd5,1'b0,1'b0,20'h0ABCD,8'h33, 1'b1,1'b1,20'h54321,8'h9E, 8'h00, 1'b1,1'b0,1'b1,20'h54321,8'h9E, 1'b0,8'h5A,8'hC3};
        vecs[19] = '{3'd6,1'b0,1'b0,20'h0ABCD,8'h33, 1'b1,1'b1,20'h54321,8'h9E, 8'hFF, 1'b1,1'b0,1'b1,20'h54321,8'h9E, 1'b0,8'h5A,8'hC3};
        vecs[20] = '{3'd7,1'b0,1'b0,20'h0ABCD,8'h33, 1'b1,1'b1,20'h54321,8'h9E, 8'h00, 1'b1,1'b1,1'b1,20'h54321,8'h9E, 1'b0,8'h5A,8'hC3};
        vecs[21] = '{3'd1,1'b0,1'b0,20'h0ABCD,8'h33, 1'b0,1'b0,20'h54321,8'h9E, 8'h00, 1'b0,1'b1,1'b0,20'h54321,8'h00, 1'b0,8'h5A,8'hC3};

        RES = 1'b1; S = 3'd0; cpu_sel = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        bg_req = 1'b0; bg_we = 1'b0; bg_addr = '0; bg_wdata = '0; RD_in = '0;
        step();
        step();
        RES = 1'b0;

        // Reset state
        @(negedge C7M);
        chk("rst_ramcs", RAMCS, 1'b0);
        chk("rst_nrwe",  nRWE,  1'b1);
        chk("rst_rdoe",  RDOE,  1'b0);
        chk("rst_ra",    RA,    20'h0);
        chk("rst_rdo",   RDo,   8'h00);
        chk("rst_ack",   bg_ack, 1'b0);
        chk("rst_bgr",   bg_rdata, 8'h00);
        chk("rst_cpur",  cpu_rdata, 8'h00);
        step();

        // Table: synced bg write, synced bg read, CPU read and write windows
        for (int i = 0; i < 22; i++) begin
            S = vecs[i].s; bg_req = vecs[i].bg_req; bg_we = vecs[i].bg_we;
            bg_addr = vecs[i].bg_addr; bg_wdata = vecs[i].bg_wdata;
            cpu_sel = vecs[i].cpu_sel; cpu_we = vecs[i].cpu_we;
            cpu_addr = vecs[i].cpu_addr; cpu_wdata = vecs[i].cpu_wdata; RD_in = vecs[i].rd_in;
            @(negedge C7M);
            chk($sformatf("vec%0d_ramcs", i), RAMCS, vecs[i].e_ramcs);
            chk($sformatf("vec%0d_nrwe", i),  nRWE,  vecs[i].e_nrwe);
            chk($sformatf("vec%0d_rdoe", i),  RDOE,  vecs[i].e_rdoe);
            chk($sformatf("vec%0d_ra", i),    RA,    vecs[i].e_ra);
            chk($sformatf("vec%0d_rdo", i),   RDo,   vecs[i].e_rdo);
            chk($sformatf("vec%0d_ack", i),   bg_ack, vecs[i].e_ack);
            chk($sformatf("vec%0d_bgr", i),   bg_rdata, vecs[i].e_bgr);
            chk($sformatf("vec%0d_cpur", i),  cpu_rdata, vecs[i].e_cpur);
            step();
        end

        // Reset asserted while the write strobe is active
        cpu_sel = 1'b0; RD_in = 8'h00;
        S = 3'd1; bg_req = 1'b1; bg_we = 1'b1; bg_addr = 20'h0F0F0; bg_wdata = 8'h11;
        step();
        S = 3'd2;
        @(negedge C7M);
        chk("rmid_addr_ramcs", RAMCS, 1'b1);
        step();
        S = 3'd3; RES = 1'b1;
        @(negedge C7M);
        chk("rmid_stb_nrwe", nRWE, 1'b0);
        step();
        RES = 1'b0;
        for (int s = 4; s <= 7; s++) begin
            S = 3'(s);
            @(negedge C7M);
            chk($sformatf("rmid_s%0d_nrwe", s),  nRWE,  1'b1);
            chk($sformatf("rmid_s%0d_ramcs", s), RAMCS, 1'b0);
            chk($sformatf("rmid_s%0d_ack", s),   bg_ack, 1'b0);
            if (s == 4) chk("rmid_bgr_cleared", bg_rdata, 8'h00);
            step();
        end
        bg_req = 1'b0;

        // Back-to-back: CPU reads 0x00100 every bus cycle while bg_req stays high
        bg_req = 1'b1; bg_we = 1'b0; bg_addr = 20'h20000; bg_wdata = 8'h44;
        cpu_we = 1'b0; cpu_addr = 20'h00100; cpu_wdata = 8'h00;
        rd_s6 = 8'h00;
        for (int bc = 0; bc < 3; bc++) begin
            acks_bc = 0;
            for (int s = 1; s <= 7; s++) begin
                S = 3'(s);
                cpu_sel = (s >= 4);
                RD_in = 8'($urandom);
                if (s == 6) rd_s6 = RD_in;
                @(negedge C7M);
                if (s == 2 || s == 3) begin
                    chk($sformatf("b2b%0d_s%0d_bgra", bc, s), RA, bg_addr);
                    chk($sformatf("b2b%0d_s%0d_cs", bc, s), RAMCS, 1'b1);
                end
                if (s >= 4) begin
                    chk($sformatf("b2b%0d_s%0d_cpura", bc, s), RA, 20'h00100);
                    chk($sformatf("b2b%0d_s%0d_cs", bc, s), RAMCS, 1'b1);
                    chk($sformatf("b2b%0d_s%0d_nrwe", bc, s), nRWE, 1'b1);
                end
                if (bg_ack) begin
                    acks_bc++;
                    chk($sformatf("b2b%0d_ack_phase", bc), S, 3'd4);
                end
                if (s == 7) chk($sformatf("b2b%0d_cpur", bc), cpu_rdata, rd_s6);
                step();
                if (s == 4) begin
                    bg_addr = bg_addr + 20'h00011;
                    bg_we = ~bg_we;
                end
            end
            chk($sformatf("b2b%0d_ops_per_cycle", bc), acks_bc, 1);
        end
        bg_req = 1'b0; cpu_sel = 1'b0;

        // Unsynced throttle: 40 cycles at S=0 with bg_req held
        bg_req = 1'b1; bg_we = 1'b0; bg_addr = 20'h33333; S = 3'd0;
        acks = 0; prev_ramcs = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge C7M);
            if (RAMCS && prev_ramcs == 0) starts.push_back(i);
            if (bg_ack) acks++;
            prev_ramcs = int'(RAMCS);
            step();
        end
        chk("thr_acks", acks, 6);
        chk("thr_starts", starts.size(), 6);
        if (starts.size() > 0) chk("thr_first_start", starts[0], 1);
        for (int k = 1; k < starts.size(); k++) begin
            // two op cycles plus FREE_GAP+1 idle cycles between launches
            idle_run = starts[k] - starts[k-1] - 2;
            chk($sformatf("thr_idle_run%0d", k), idle_run, FREE_GAP + 1);
        end
        bg_req = 1'b0;
        S = 3'd7;
        step();
        step();

        // Resync mid-op: launch at S=0, then S jumps to 1
        S = 3'd0; bg_req = 1'b1; bg_we = 1'b1; bg_addr = 20'h3C3C3; bg_wdata = 8'h5C;
        @(negedge C7M);
        chk("rsy_idle_ramcs", RAMCS, 1'b0);
        step();
        S = 3'd1;
        @(negedge C7M);
        chk("rsy_s1_ramcs", RAMCS, 1'b1);
        chk("rsy_s1_nrwe", nRWE, 1'b1);
        chk("rsy_s1_ra", RA, 20'h3C3C3);
        step();
        S = 3'd2;
        @(negedge C7M);
        chk("rsy_s2_nrwe", nRWE, 1'b0);
        chk("rsy_s2_ramcs", RAMCS, 1'b1);
        step();
        S = 3'd3;
        @(negedge C7M);
        chk("rsy_s3_ack", bg_ack, 1'b1);
        chk("rsy_s3_ramcs", RAMCS, 1'b0);
        step();
        bg_req = 1'b0; cpu_sel = 1'b1; cpu_we = 1'b1; cpu_addr = 20'h00200; cpu_wdata = 8'h66;
        for (int s = 4; s <= 7; s++) begin
            S = 3'(s);
            @(negedge C7M);
            chk($sformatf("rsy_s%0d_ra", s), RA, 20'h00200);
            chk($sformatf("rsy_s%0d_rdo", s), RDo, 8'h66);
            chk($sformatf("rsy_s%0d_ack", s), bg_ack, 1'b0);
            chk($sformatf("rsy_s%0d_nrwe", s), nRWE, (s == 5 || s == 6) ? 1'b0 : 1'b1);
            step();
        end
        cpu_sel = 1'b0;

        // Randomized run against the reference model
        RES = 1'b1; S = 3'd1;
        step();
        RES = 1'b0;
        m_op_age = 0; m_gap = 0; m_ack = 1'b0; m_bgr = 8'h00; m_cpur = 8'h00; m_ra_last = 20'h0;
        pend = 1'b0; saw_ack = 1'b0; sync_mode = 1'b1; run = 0;
        for (int c = 0; c < 3000; c++) begin
            if (sync_mode) begin
                if ($urandom_range(0, 59) == 0) begin
                    sync_mode = 1'b0; run = $urandom_range(3, 30); S = 3'd0;
                end else begin
                    S = (S == 3'd7 || S == 3'd0) ? 3'd1 : S + 3'd1;
                end
            end else begin
                run--;
                if (run <= 0) begin
                    sync_mode = 1'b1; S = 3'($urandom_range(1, 7));
                end else begin
                    S = 3'd0;
                end
            end
            if (saw_ack) pend = 1'b0;
            else if (pend && $urandom_range(0, 99) == 0) pend = 1'b0;
            else if (!pend && $urandom_range(0, 2) == 0) begin
                pend = 1'b1;
                bg_we = 1'($urandom);
                bg_addr = 20'($urandom);
                bg_wdata = 8'($urandom);
            end
            bg_req = pend;
            cpu_sel = 1'($urandom);
            cpu_we = 1'($urandom);
            cpu_addr = 20'($urandom);
            cpu_wdata = 8'($urandom);
            RD_in = 8'($urandom);
            @(negedge C7M);
            model_pins(e_ramcs, e_nrwe, e_rdoe, e_ra, e_rdo);
            chk($sformatf("rnd%0d_ramcs", c), RAMCS, e_ramcs);
            chk($sformatf("rnd%0d_nrwe", c),  nRWE,  e_nrwe);
            chk($sformatf("rnd%0d_rdoe", c),  RDOE,  e_rdoe);
            chk($sformatf("rnd%0d_ra", c),    RA,    e_ra);
            chk($sformatf("rnd%0d_rdo", c),   RDo,   e_rdo);
            chk($sformatf("rnd%0d_ack", c),   bg_ack, m_ack);
            chk($sformatf("rnd%0d_bgr", c),   bg_rdata, m_bgr);
            chk($sformatf("rnd%0d_cpur", c),  cpu_rdata, m_cpur);
            saw_ack = bg_ack;
            @(posedge C7M);
            model_edge();
            #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
